// File: rtl/sd_pkg.sv
// Shared types for the sigma-delta background controller: pixel width,
// background/variance RAM word and the stage-1 pipeline record.
package sd_pkg;

    localparam int PIX_W         = 8;
    // Upper bound on the per-frame address width carried in the S1 record.
    localparam int SD_ADDR_MAX_W = 24;

    typedef struct packed {
        logic [PIX_W-1:0] bg;
        logic [PIX_W-1:0] var_;
    } bgvar_t;

    typedef struct packed {
        logic [PIX_W-1:0]         pixel;
        logic [SD_ADDR_MAX_W-1:0] addr;
        logic                     eof;
        logic                     init;
    } s1_t;

endpackage

// File: rtl/sd_bgvar_ram.sv
// Per-pixel background/variance store: one write port, one synchronous read
// port whose output register holds while rd_en is low.
module sd_bgvar_ram
    import sd_pkg::*;
#(
    parameter int NUM_PIXELS = 76800
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_PIXELS)-1:0] wr_addr,
    input  bgvar_t                        wr_data,
    input  logic                          rd_en,
    input  logic [$clog2(NUM_PIXELS)-1:0] rd_addr,
    output bgvar_t                        rd_data
);

    bgvar_t mem [NUM_PIXELS];
    bgvar_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sigma_delta_bg_ctrl.sv
// Frame-side driver for the sigma-delta update unit: accepts raster pixels,
// feeds stored background/variance to the unit, writes results back, emits the mask.
module sigma_delta_bg_ctrl
    import sd_pkg::*;
#(
    parameter int NUM_PIXELS = 76800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_sof,
    input  logic             init_req,
    output logic             sd_enable,
    output logic             sd_wr_background,
    output logic [PIX_W-1:0] sd_curr_pixel,
    output logic [PIX_W-1:0] sd_background,
    output logic [PIX_W-1:0] sd_variance,
    input  logic [PIX_W-1:0] sd_background_next,
    input  logic [PIX_W-1:0] sd_variance_next,
    input  logic             sd_motion_detected,
    output logic             mask_valid,
    input  logic             mask_ready,
    output logic             mask_bit,
    output logic             mask_eof,
    output logic             frame_done
);

    localparam int                       ADDR_W     = $clog2(NUM_PIXELS);
    localparam logic [ADDR_W-1:0]        LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [SD_ADDR_MAX_W-1:0] ADDR_LIMIT = SD_ADDR_MAX_W'(NUM_PIXELS);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              init_frame_q, init_frame_d;
    logic              init_pend_q, init_pend_d;
    logic              s1_valid_q, s1_valid_d;
    s1_t               s1_q, s1_d;
    logic              mask_valid_q, mask_valid_d;
    logic              mask_bit_q, mask_bit_d;
    logic              mask_eof_q, mask_eof_d;

    logic              advance;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_eof;
    logic              start_init;
    logic              ram_wr_en;
    bgvar_t            ram_rd_data;
    bgvar_t            ram_wr_data;

    assign advance    = !mask_valid_q || mask_ready;
    assign accept     = pix_valid && advance;
    assign acc_addr   = pix_sof ? '0 : addr_q;
    assign acc_eof    = (acc_addr == LAST_ADDR);
    assign start_init = init_pend_q && (acc_addr == '0);

    // A pending init request only takes hold at the first pixel of a frame;
    // a request arriving with the eof pixel survives the eof clear.
    always_comb begin
        addr_d       = addr_q;
        init_frame_d = init_frame_q;
        init_pend_d  = init_pend_q;
        if (accept) begin
            addr_d = acc_eof ? '0 : acc_addr + ADDR_W'(1);
            if (acc_eof) begin
                init_frame_d = 1'b0;
            end else if (start_init) begin
                init_frame_d = 1'b1;
            end
            if (start_init) begin
                init_pend_d = 1'b0;
            end
        end
        if (init_req) begin
            init_pend_d = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (advance) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_d.pixel = pix_data;
                s1_d.addr  = SD_ADDR_MAX_W'(acc_addr);
                s1_d.eof   = acc_eof;
                s1_d.init  = init_frame_q || start_init;
            end
        end
    end

    always_comb begin
        mask_valid_d = mask_valid_q;
        mask_bit_d   = mask_bit_q;
        mask_eof_d   = mask_eof_q;
        if (advance) begin
            mask_valid_d = s1_valid_q;
            mask_bit_d   = s1_valid_q && !s1_q.init && sd_motion_detected;
            mask_eof_d   = s1_valid_q && s1_q.eof;
        end
    end

    // Update-unit interface is gated by S1 so it reads as zero when S1 is empty.
    assign sd_enable        = s1_valid_q && advance;
    assign sd_wr_background = s1_valid_q && s1_q.init;
    assign sd_curr_pixel    = s1_valid_q ? s1_q.pixel : '0;
    assign sd_background    = s1_valid_q ? ram_rd_data.bg : '0;
    assign sd_variance      = s1_valid_q ? ram_rd_data.var_ : '0;

    assign ram_wr_en   = sd_enable && (s1_q.addr < ADDR_LIMIT);
    assign ram_wr_data = {sd_background_next, sd_variance_next};

    sd_bgvar_ram #(
        .NUM_PIXELS(NUM_PIXELS)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_wr_en),
        .wr_addr(s1_q.addr[ADDR_W-1:0]),
        .wr_data(ram_wr_data),
        .rd_en  (advance),
        .rd_addr(acc_addr),
        .rd_data(ram_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            init_frame_q <= 1'b1;
            init_pend_q  <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            mask_valid_q <= 1'b0;
            mask_bit_q   <= 1'b0;
            mask_eof_q   <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            init_frame_q <= init_frame_d;
            init_pend_q  <= init_pend_d;
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            mask_valid_q <= mask_valid_d;
            mask_bit_q   <= mask_bit_d;
            mask_eof_q   <= mask_eof_d;
        end
    end

    assign pix_ready  = advance;
    assign mask_valid = mask_valid_q;
    assign mask_bit   = mask_bit_q;
    assign mask_eof   = mask_eof_q;
    assign frame_done = mask_valid_q && mask_ready && mask_eof_q;

endmodule

// File: tb/tb_sigma_delta_bg_ctrl.sv
// Bench for sigma_delta_bg_ctrl on a 4-pixel frame: behavioural update unit,
// frame-level background/variance model and a two-slot pipeline expectation.
module tb_sigma_delta_bg_ctrl;

    localparam int NP = 4;
    localparam int AW = $clog2(NP);

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       pix_sof;
    logic       init_req;
    logic       sd_enable;
    logic       sd_wr_background;
    logic [7:0] sd_curr_pixel;
    logic [7:0] sd_background;
    logic [7:0] sd_variance;
    logic [7:0] sd_background_next;
    logic [7:0] sd_variance_next;
    logic       sd_motion_detected;
    logic       mask_valid;
    logic       mask_ready;
    logic       mask_bit;
    logic       mask_eof;
    logic       frame_done;

    typedef struct {
        logic [7:0] pixel;
        logic [7:0] bg;
        logic [7:0] vr;
        bit         eof;
        bit         init;
        bit         mask;
    } item_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: what the RAM should hold per address, plus frame flags
    logic [7:0]    m_bg  [NP];
    logic [7:0]    m_var [NP];
    logic [AW-1:0] m_addr;
    bit            m_init;
    bit            m_pend;
    bit            m_acc;
    bit            s1_v;
    bit            out_v;
    item_t         s1_i;
    item_t         out_i;

    always #5 clk = ~clk;

    // Simple sigma-delta unit: init copies the pixel, otherwise step toward it
    function automatic logic [16:0] sdUpdate(input logic [7:0] pix, input logic [7:0] bg,
                                             input logic [7:0] vr, input logic wr);
        int         d;
        int         tgt;
        logic [7:0] bgn;
        logic [7:0] vrn;
        logic       mot;
        if (wr) return {1'b0, pix, 8'd20};
        d   = (pix > bg) ? int'(pix) - int'(bg) : int'(bg) - int'(pix);
        tgt = (2 * d > 255) ? 255 : 2 * d;
        bgn = (pix > bg) ? bg + 8'd1 : ((pix < bg) ? bg - 8'd1 : bg);
        vrn = (int'(vr) < tgt) ? vr + 8'd1 : ((int'(vr) > tgt && vr > 8'd2) ? vr - 8'd1 : vr);
        mot = d > int'(vr);
        return {mot, bgn, vrn};
    endfunction

    assign {sd_motion_detected, sd_background_next, sd_variance_next} =
        sdUpdate(sd_curr_pixel, sd_background, sd_variance, sd_wr_background);

    sigma_delta_bg_ctrl #(
        .NUM_PIXELS(NP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pix_valid         (pix_valid),
        .pix_ready         (pix_ready),
        .pix_data          (pix_data),
        .pix_sof           (pix_sof),
        .init_req          (init_req),
        .sd_enable         (sd_enable),
        .sd_wr_background  (sd_wr_background),
        .sd_curr_pixel     (sd_curr_pixel),
        .sd_background     (sd_background),
        .sd_variance       (sd_variance),
        .sd_background_next(sd_background_next),
        .sd_variance_next  (sd_variance_next),
        .sd_motion_detected(sd_motion_detected),
        .mask_valid        (mask_valid),
        .mask_ready        (mask_ready),
        .mask_bit          (mask_bit),
        .mask_eof          (mask_eof),
        .frame_done        (frame_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        m_addr = '0;
        m_init = 1'b1;
        m_pend = 1'b0;
        m_acc  = 1'b0;
        s1_v   = 1'b0;
        out_v  = 1'b0;
    endtask

    // Compare every observable output with the expected pipeline contents
    task automatic checkCycle();
        bit adv;
        adv = !out_v || mask_ready;
        checkOutput("pix_ready", 32'(pix_ready), 32'(adv));
        checkOutput("mask_valid", 32'(mask_valid), 32'(out_v));
        checkOutput("sd_enable", 32'(sd_enable), 32'(s1_v && adv));
        checkOutput("sd_wr_background", 32'(sd_wr_background), 32'(s1_v && s1_i.init));
        checkOutput("frame_done", 32'(frame_done), 32'(out_v && mask_ready && out_i.eof));
        if (out_v) begin
            checkOutput("mask_bit", 32'(mask_bit), 32'(out_i.mask));
            checkOutput("mask_eof", 32'(mask_eof), 32'(out_i.eof));
        end
        if (s1_v) begin
            checkOutput("sd_curr_pixel", 32'(sd_curr_pixel), 32'(s1_i.pixel));
            if (!s1_i.init) begin
                checkOutput("sd_background", 32'(sd_background), 32'(s1_i.bg));
                checkOutput("sd_variance", 32'(sd_variance), 32'(s1_i.vr));
            end
        end
    endtask

    // Apply the frame rules to whatever the bench drove into this clock edge
    task automatic modelEdge();
        bit            adv;
        bit            eof;
        bit            start;
        logic [AW-1:0] a;
        logic [16:0]   upd;
        item_t         it;
        adv   = !out_v || mask_ready;
        m_acc = pix_valid && adv;
        it    = s1_i;
        if (m_acc) begin
            a        = pix_sof ? '0 : m_addr;
            eof      = (a == AW'(NP - 1));
            start    = m_pend && (a == '0);
            it.pixel = pix_data;
            it.bg    = m_bg[a];
            it.vr    = m_var[a];
            it.eof   = eof;
            it.init  = m_init || start;
            upd      = sdUpdate(pix_data, m_bg[a], m_var[a], it.init);
            it.mask  = it.init ? 1'b0 : upd[16];
            m_bg[a]  = upd[15:8];
            m_var[a] = upd[7:0];
            m_addr   = eof ? '0 : a + AW'(1);
            if (eof) m_init = 1'b0;
            else if (start) m_init = 1'b1;
            if (start) m_pend = 1'b0;
        end
        if (init_req) m_pend = 1'b1;
        if (adv) begin
            out_v = s1_v;
            out_i = s1_i;
            s1_v  = m_acc;
            s1_i  = it;
        end
    endtask

    task automatic applyStimulus(input int v, input int d, input int sof, input int ireq, input int mr);
        pix_valid  = (v != 0);
        pix_data   = 8'(d);
        pix_sof    = (sof != 0);
        init_req   = (ireq != 0);
        mask_ready = (mr != 0);
        #1;
        checkCycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic sendPixel(input int d, input int sof, input int ireq);
        applyStimulus(1, d, sof, ireq, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1);
    endtask

    initial begin
        int p;
        int cur_pix;
        rst        = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 8'd0;
        pix_sof    = 1'b0;
        init_req   = 1'b0;
        mask_ready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            m_bg[i]  = 8'd0;
            m_var[i] = 8'd0;
        end
        modelReset();

        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_mask_valid", 32'(mask_valid), 32'd0);
        checkOutput("rst_mask_bit", 32'(mask_bit), 32'd0);
        checkOutput("rst_mask_eof", 32'(mask_eof), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_sd_enable", 32'(sd_enable), 32'd0);
        checkOutput("rst_sd_wr_bg", 32'(sd_wr_background), 32'd0);
        checkOutput("rst_sd_curr_pixel", 32'(sd_curr_pixel), 32'd0);
        checkOutput("rst_sd_background", 32'(sd_background), 32'd0);
        checkOutput("rst_sd_variance", 32'(sd_variance), 32'd0);
        checkOutput("rst_pix_ready", 32'(pix_ready), 32'd1);
        rst = 1'b1;
        idle(1);

        // Initialisation frame, then a frame with one moving pixel
        sendPixel(10, 1, 0); sendPixel(20, 0, 0); sendPixel(30, 0, 0); sendPixel(40, 0, 0);
        sendPixel(10, 1, 0); sendPixel(20, 0, 0); sendPixel(200, 0, 0); sendPixel(40, 0, 0);
        idle(2);

        // Downstream stall mid-frame, with an init request on the way
        sendPixel(15, 1, 0); sendPixel(22, 0, 1);
        repeat (5) applyStimulus(1, 33, 0, 0, 0);
        sendPixel(33, 0, 0); sendPixel(90, 0, 0);
        idle(1);

        // Requested init frame
        sendPixel(50, 1, 0); sendPixel(60, 0, 0); sendPixel(70, 0, 0); sendPixel(80, 0, 0);

        // Restart on the third pixel
        sendPixel(51, 1, 0); sendPixel(61, 0, 0); sendPixel(200, 1, 0);
        sendPixel(62, 0, 0); sendPixel(71, 0, 0); sendPixel(81, 0, 0);
        idle(2);

        // Init request together with the eof pixel makes the next frame an init frame
        sendPixel(52, 1, 0); sendPixel(5, 0, 0); sendPixel(72, 0, 0); sendPixel(250, 0, 1);
        sendPixel(100, 1, 0); sendPixel(110, 0, 0); sendPixel(120, 0, 0); sendPixel(130, 0, 0);
        sendPixel(101, 1, 0); sendPixel(111, 0, 0);

        // Asynchronous reset while stalled
        applyStimulus(1, 125, 0, 0, 0);
        applyStimulus(1, 125, 0, 0, 0);
        rst = 1'b0;
        #1;
        checkOutput("async_mask_valid", 32'(mask_valid), 32'd0);
        checkOutput("async_sd_enable", 32'(sd_enable), 32'd0);
        checkOutput("async_frame_done", 32'(frame_done), 32'd0);
        checkOutput("async_sd_wr_bg", 32'(sd_wr_background), 32'd0);
        checkOutput("async_sd_curr_pixel", 32'(sd_curr_pixel), 32'd0);
        checkOutput("async_pix_ready", 32'(pix_ready), 32'd1);
        pix_valid  = 1'b0;
        mask_ready = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        idle(1);
        sendPixel(9, 1, 0); sendPixel(19, 0, 0); sendPixel(29, 0, 0); sendPixel(39, 0, 0);
        sendPixel(9, 1, 0); sendPixel(240, 0, 0); sendPixel(29, 0, 0); sendPixel(39, 0, 0);

        // Randomised frames with gaps, back-pressure and idle-cycle init requests
        for (int f = 0; f < 10; f++) begin
            p       = 0;
            cur_pix = int'($urandom_range(255));
            while (p < NP) begin
                if ($urandom_range(3) == 0) begin
                    applyStimulus(0, 0, 0, int'($urandom_range(11) == 0), int'($urandom_range(2) != 0));
                end else begin
                    applyStimulus(1, cur_pix, int'(p == 0), 0, int'($urandom_range(3) != 0));
                    if (m_acc) begin
                        p++;
                        cur_pix = ($urandom_range(1) == 0) ? int'($urandom_range(255))
                                                           : int'(m_bg[AW'(p % NP)]) + int'($urandom_range(6)) - 3;
                        cur_pix = (cur_pix < 0) ? 0 : ((cur_pix > 255) ? 255 : cur_pix);
                    end
                end
            end
        end
        idle(4);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
